// File: rtl/bird_physics_writer.sv
`default_nettype none
// ============================================================================
// Module      : bird_physics_writer
// Description : Bird vertical physics (gravity, flap, ceiling/ground) and the
//               IDLE/PLAY/DEAD game state, updated once per video frame.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_physics_writer #(
    parameter int SCREEN_HEIGHT = 480,
    parameter int BIRD_HEIGHT   = 35,
    parameter int START_Y       = 200,
    parameter int GRAVITY       = 1,
    parameter int FLAP_VELOCITY = 8,
    parameter int MAX_FALL      = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    output logic [31:0] bird_reg,
    output logic        bird_update,
    output logic [1:0]  game_state
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PLAY = 2'd1;
    localparam logic [1:0] c_DEAD = 2'd2;

    localparam logic signed [10:0] c_FLAP_VEL = -$signed(11'(FLAP_VELOCITY));
    localparam logic signed [10:0] c_GRAVITY  = $signed(11'(GRAVITY));
    localparam logic signed [10:0] c_MAX_FALL = $signed(11'(MAX_FALL));
    localparam logic signed [10:0] c_GROUND   = $signed(11'(SCREEN_HEIGHT - BIRD_HEIGHT));
    localparam logic [8:0]         c_GROUND_Y = 9'(SCREEN_HEIGHT - BIRD_HEIGHT - 1);
    localparam logic [8:0]         c_START_Y  = 9'(START_Y);

    logic [1:0] r_state;
    logic [8:0] r_y;
    logic [7:0] r_vel;
    logic       r_flap_q;
    logic       r_pending;
    logic       r_update;

    logic                w_rise;
    logic signed [10:0]  w_vel_ext;
    logic signed [10:0]  w_grav;
    logic signed [10:0]  w_fall;
    logic signed [10:0]  w_vel_n;
    logic signed [10:0]  w_ny;

    assign w_rise    = flap & ~r_flap_q;
    assign w_vel_ext = $signed({{3{r_vel[7]}}, r_vel});
    assign w_grav    = w_vel_ext + c_GRAVITY;
    assign w_fall    = (w_grav > c_MAX_FALL) ? c_MAX_FALL : w_grav;
    // A flap rising on the tick cycle itself still counts for that tick.
    assign w_vel_n   = (r_pending | w_rise) ? c_FLAP_VEL : w_fall;
    assign w_ny      = $signed({2'b00, r_y}) + w_vel_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_y       <= c_START_Y;
            r_vel     <= 8'd0;
            r_flap_q  <= 1'b0;
            r_pending <= 1'b0;
            r_update  <= 1'b0;
        end else begin
            r_flap_q <= flap;
            r_update <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        r_state <= c_PLAY;
                        r_vel   <= c_FLAP_VEL[7:0];
                    end
                end
                c_PLAY: begin
                    if (collision) begin
                        r_state <= c_DEAD;
                    end else if (frame_tick) begin
                        r_pending <= 1'b0;
                        r_update  <= 1'b1;
                        if (w_ny < 11'sd0) begin
                            r_y   <= 9'd0;
                            r_vel <= 8'd0;
                        end else if (w_ny >= c_GROUND) begin
                            r_y     <= c_GROUND_Y;
                            r_vel   <= 8'd0;
                            r_state <= c_DEAD;
                        end else begin
                            r_y   <= w_ny[8:0];
                            r_vel <= w_vel_n[7:0];
                        end
                    end else if (w_rise) begin
                        r_pending <= 1'b1;
                    end
                end
                c_DEAD: begin
                    if (w_rise) begin
                        r_state   <= c_IDLE;
                        r_y       <= c_START_Y;
                        r_vel     <= 8'd0;
                        r_pending <= 1'b0;
                        r_update  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bird_reg    = {23'd0, r_y};
    assign bird_update = r_update;
    assign game_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bird_physics_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_physics_writer
// Description : Randomized scoreboard bench for bird_physics_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_physics_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        flap = 1'b0;
    logic        collision = 1'b0;
    logic [31:0] bird_reg;
    logic        bird_update;
    logic [1:0]  game_state;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] reg_v;
        logic        upd;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference game model in plain integers
    int m_state = 0;
    int m_y     = 200;
    int m_vel   = 0;
    int m_pend  = 0;
    int m_prev  = 0;
    int m_upd   = 0;

    bird_physics_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collision  (collision),
        .bird_reg   (bird_reg),
        .bird_update(bird_update),
        .game_state (game_state)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic t, input logic f, input logic c);
        int rise;
        int v;
        int ny;
        if (!r) begin
            m_state = 0; m_y = 200; m_vel = 0; m_pend = 0; m_prev = 0; m_upd = 0;
        end else begin
            rise   = (f && m_prev == 0) ? 1 : 0;
            m_prev = f ? 1 : 0;
            m_upd  = 0;
            if (m_state == 0) begin
                if (rise != 0) begin
                    m_state = 1;
                    m_vel   = -8;
                end
            end else if (m_state == 1) begin
                if (c) begin
                    m_state = 2;
                end else if (t) begin
                    if (m_pend != 0 || rise != 0) v = -8;
                    else v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
                    ny     = m_y + v;
                    m_upd  = 1;
                    m_pend = 0;
                    if (ny < 0) begin
                        m_y = 0; m_vel = 0;
                    end else if (ny >= 480 - 35) begin
                        m_y = 444; m_vel = 0; m_state = 2;
                    end else begin
                        m_y = ny; m_vel = v;
                    end
                end else if (rise != 0) begin
                    m_pend = 1;
                end
            end else begin
                if (rise != 0) begin
                    m_state = 0; m_y = 200; m_vel = 0; m_pend = 0; m_upd = 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic t, input logic f, input logic c);
        exp_t e;
        @(negedge clk);
        reset_n    = r;
        frame_tick = t;
        flap       = f;
        collision  = c;
        model_step(r, t, f, c);
        e.st    = 2'(m_state);
        e.reg_v = 32'(m_y);
        e.upd   = (m_upd != 0);
        q.push_back(e);
    endtask

    task automatic tick_gap();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every edge whose stimulus was issued yields one observation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (game_state !== e.st || bird_reg !== e.reg_v || bird_update !== e.upd) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t: got state=%0d bird_reg=%0d upd=%0b, expected state=%0d bird_reg=%0d upd=%0b",
                             $time, game_state, bird_reg, bird_update, e.st, e.reg_v, e.upd);
                end
            end
        end
    end

    initial begin
        // Reset and idle frames
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick_gap();

        // Start play and three gravity-only frames
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick_gap();

        // Free fall to the ground, extra ticks ignored in DEAD
        repeat (40) tick_gap();

        // Restart from DEAD
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Flap every frame until the ceiling clamp engages
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_gap();
        for (int i = 0; i < 28; i++) begin
            if (i % 3 == 0) begin
                step(1'b1, 1'b1, 1'b1, 1'b0);
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                step(1'b1, 1'b0, 1'b1, 1'b0);
                step(1'b1, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b1, 1'b0, 1'b0);
            end
        end

        // Collision together with a tick, then restart
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) tick_gap();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of play
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick_gap();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 80) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d observations outstanding, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
